// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_prog_if.sv
// Control and output bundle for the programmable clock divider.
// YN exists only when GF180MCU_OSU_CLKDIV_YN_EN is defined.
interface gf180mcu_osu_sc_gp12t3v3__clkdiv_prog_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic [WIDTH-1:0] DIV;
    logic             Y;
    logic             ACTIVE;
`ifdef GF180MCU_OSU_CLKDIV_YN_EN
    logic             YN;

    modport master (output EN, DIV, input Y, ACTIVE, YN);
    modport slave  (input EN, DIV, output Y, ACTIVE, YN);
`else
    modport master (output EN, DIV, input Y, ACTIVE);
    modport slave  (input EN, DIV, output Y, ACTIVE);
`endif
endinterface

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.sv
// Glitch-free programmable integer clock divider; ratio/enable changes land only on period wraps.
// Optional registered complement output YN under GF180MCU_OSU_CLKDIV_YN_EN.
module gf180mcu_osu_sc_gp12t3v3__clkdiv_prog #(
    parameter int WIDTH = 4
) (
    input logic CLK,
    input logic RN,
    gf180mcu_osu_sc_gp12t3v3__clkdiv_prog_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] r_q, r_n;
    logic [WIDTH-1:0] reff;
    logic [WIDTH:0]   high;
    logic             y_q, y_n;
    logic             wrap;

    assign reff = (bus.DIV < WIDTH'(2)) ? WIDTH'(2) : bus.DIV;
    // One extra bit so ceil(r/2) cannot overflow at the maximum ratio.
    assign high = ({1'b0, r_q} + (WIDTH+1)'(1)) >> 1;
    assign wrap = (cnt == r_q - WIDTH'(1));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        r_n     = r_q;
        y_n     = y_q;
        case (state)
            IDLE: begin
                cnt_n = '0;
                y_n   = 1'b0;
                if (bus.EN) begin
                    r_n     = reff;
                    y_n     = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_n = '0;
                    if (bus.EN) begin
                        r_n = reff;
                        y_n = 1'b1;
                    end else begin
                        y_n     = 1'b0;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + WIDTH'(1);
                    y_n   = ({1'b0, cnt_n} < high);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            cnt   <= '0;
            r_q   <= WIDTH'(2);
            y_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            r_q   <= r_n;
            y_q   <= y_n;
        end
    end

`ifdef GF180MCU_OSU_CLKDIV_YN_EN
    // Separate flop so Y and YN switch on the same edge without inverter skew.
    logic yn_q;
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) yn_q <= 1'b1;
        else     yn_q <= ~y_n;
    end
    assign bus.YN = yn_q;
`endif

    assign bus.Y      = y_q;
    assign bus.ACTIVE = (state == RUN);
endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.sv
// Bench for the programmable clock divider: period-queue reference model plus directed literal sequences.
module tb_gf180mcu_osu_sc_gp12t3v3__clkdiv_prog;
    localparam int W = 4;

    logic CLK = 1'b0;
    logic RN  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   checking = 1'b0;

    gf180mcu_osu_sc_gp12t3v3__clkdiv_prog_if #(.WIDTH(W)) bus();

    gf180mcu_osu_sc_gp12t3v3__clkdiv_prog #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RN  (RN),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Reference: queue holds the Y values still to be shown in the current period.
    bit mq[$];
    always @(posedge CLK or negedge RN) begin
        if (!RN) mq.delete();
        else begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (mq.size() == 0 && bus.EN === 1'b1) begin
                int r, h;
                r = (int'(bus.DIV) < 2) ? 2 : int'(bus.DIV);
                h = (r + 1) / 2;
                for (int i = 0; i < r; i++) mq.push_back(i < h);
            end
        end
    end

    always @(negedge CLK) begin
        if (checking) begin
            logic ey, ea;
            ey = (mq.size() != 0) ? mq[0] : 1'b0;
            ea = (mq.size() != 0);
            checks++;
            if (bus.Y !== ey || bus.ACTIVE !== ea) begin
                errors++;
                $display("FAIL model_cmp t=%0t Y=%b ACTIVE=%b expected Y=%b ACTIVE=%b", $time, bus.Y, bus.ACTIVE, ey, ea);
            end
`ifdef GF180MCU_OSU_CLKDIV_YN_EN
            checks++;
            if (bus.YN !== ~ey) begin
                errors++;
                $display("FAIL yn_cmp t=%0t YN=%b expected %b", $time, bus.YN, ~ey);
            end
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2 RN = 1'b0;
        bus.EN = 1'b0;
        #4 RN = 1'b1;
    endtask

    task automatic start(input logic [W-1:0] d);
        bus.DIV = d;
        bus.EN  = 1'b1;
        step();
    endtask

    // Samples Y/ACTIVE n times starting at the current cycle; optional input events at sample i.
    task automatic run_seq(input int n, input int i_div, input logic [W-1:0] nd,
                           input int i_en0, input int i_en1,
                           output logic [15:0] ys, output logic [15:0] as);
        ys = '0;
        as = '0;
        for (int i = 0; i < n; i++) begin
            if (i == i_div) bus.DIV = nd;
            if (i == i_en0) bus.EN = 1'b0;
            if (i == i_en1) bus.EN = 1'b1;
            ys = {ys[14:0], bus.Y};
            as = {as[14:0], bus.ACTIVE};
            step();
        end
    endtask

    initial begin
        logic [15:0] ys, as;
        bus.EN  = 1'b0;
        bus.DIV = '0;
        #12;
        chk("reset_y", {31'd0, bus.Y}, 32'd0);
        chk("reset_active", {31'd0, bus.ACTIVE}, 32'd0);
`ifdef GF180MCU_OSU_CLKDIV_YN_EN
        chk("reset_yn", {31'd0, bus.YN}, 32'd1);
`endif
        #4 RN = 1'b1;
        checking = 1'b1;

        start(4'd4);
        chk("div4_first_active", {31'd0, bus.ACTIVE}, 32'd1);
        run_seq(8, -1, 0, -1, -1, ys, as);
        chk("div4_y", {16'd0, ys}, 32'b11001100);

        do_reset();
        start(4'd5);
        run_seq(10, -1, 0, -1, -1, ys, as);
        chk("div5_y", {16'd0, ys}, 32'b1110011100);

        do_reset();
        start(4'd0);
        run_seq(4, -1, 0, -1, -1, ys, as);
        chk("div0_y", {16'd0, ys}, 32'b1010);

        do_reset();
        start(4'd1);
        run_seq(4, -1, 0, -1, -1, ys, as);
        chk("div1_y", {16'd0, ys}, 32'b1010);

        do_reset();
        start(4'd6);
        run_seq(12, 1, 4'd3, -1, -1, ys, as);
        chk("div6to3_y", {16'd0, ys}, 32'b111000110110);

        do_reset();
        start(4'd8);
        run_seq(12, -1, 0, 2, -1, ys, as);
        chk("stop_y", {16'd0, ys}, 32'b111100000000);
        chk("stop_active", {16'd0, as}, 32'b111111110000);

        do_reset();
        start(4'd8);
        run_seq(12, -1, 0, 2, 5, ys, as);
        chk("cancel_y", {16'd0, ys}, 32'b111100001111);
        chk("cancel_active", {16'd0, as}, 32'hFFF);

        do_reset();
        start(4'd4);
        step();
        #2 RN = 1'b0;
        #1;
        chk("async_rst_y", {31'd0, bus.Y}, 32'd0);
        chk("async_rst_active", {31'd0, bus.ACTIVE}, 32'd0);
`ifdef GF180MCU_OSU_CLKDIV_YN_EN
        chk("async_rst_yn", {31'd0, bus.YN}, 32'd1);
`endif
        bus.DIV = 4'd7;
        bus.EN  = 1'b1;
        #2 RN = 1'b1;
        step();
        run_seq(7, -1, 0, -1, -1, ys, as);
        chk("post_rst_div7_y", {16'd0, ys}, 32'b1111000);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 6) == 0) bus.EN = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) bus.DIV = W'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) begin
                #2 RN = 1'b0;
                #3 RN = 1'b1;
            end
            step();
        end

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
